// File: rtl/pipelined_csel_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder: default geometry and mode encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipelined_csel_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLOCK = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Number of pipeline stages: one carry-select block per stage.
    function automatic int calc_nstg(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/csel_block.sv
// One BLOCK-bit carry-select slice: both carry-in candidates summed in parallel, then muxed.
// Latency: combinational.
// Backpressure: none (pure datapath).
module csel_block
    import pipelined_csel_adder_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_s,
    output logic             o_c
);

    logic [BLOCK:0] w_sum0;
    logic [BLOCK:0] w_sum1;

    // Speculative sums for carry-in 0 and carry-in 1; the late-arriving carry only drives the mux.
    assign w_sum0     = {1'b0, i_a} + {1'b0, i_b};
    assign w_sum1     = {1'b0, i_a} + {1'b0, i_b} + {{BLOCK{1'b0}}, 1'b1};
    assign {o_c, o_s} = i_cin ? w_sum1 : w_sum0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined add/subtract: stage k resolves bits [k*BLOCK +: BLOCK] from the previous stage's registered carry.
// Latency: NSTG cycles from accepted operands to out_VALID; one result per cycle when unstalled.
// Backpressure: valid/ready; stages stall from the tail on in_READY=0, out_READY drops when stage 0 cannot move.
module pipelined_csel_adder
    import pipelined_csel_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             in_CLK,
    input  logic             in_RST_N,
    input  logic             in_VALID,
    output logic             out_READY,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_C,
    input  logic             in_SUB,
    output logic             out_VALID,
    input  logic             in_READY,
    output logic [WIDTH-1:0] out_S,
    output logic             out_C,
    output logic             out_V
);

    localparam int NSTG = calc_nstg(WIDTH, BLOCK);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;
    logic [NSTG-1:0]  r_vld;
    logic [NSTG-1:0]  w_adv;
    logic [NSTG-1:0]  w_cy;

    // Subtraction is A + ~B + 1; the external carry-in only matters when adding.
    assign w_sub   = (mode_e'(in_SUB) == MODE_SUB);
    assign w_b_eff = w_sub ? ~in_B : in_B;
    assign w_cin0  = w_sub ? 1'b1 : in_C;

    // Advance chain: a stage moves when it is empty or everything downstream of it moves.
    always_comb begin : p_adv
        logic w_acc;
        w_acc         = ~r_vld[NSTG-1] | in_READY;
        w_adv         = '0;
        w_adv[NSTG-1] = w_acc;
        for (int k = NSTG - 2; k >= 0; k--) begin
            w_acc    = ~r_vld[k] | w_acc;
            w_adv[k] = w_acc;
        end
    end

    // Held low while in reset so nothing is offered an accept before the pipeline is live.
    assign out_READY = in_RST_N & w_adv[0];
    assign out_VALID = r_vld[NSTG-1];
    assign out_C     = w_cy[NSTG-1];

    // Valid bits ripple forward under their stage's advance enable.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            r_vld <= '0;
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= in_VALID;
            end
            for (int k = 1; k < NSTG; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    for (genvar gk = 0; gk < NSTG; gk++) begin : g_blk
        logic [BLOCK-1:0] w_a;
        logic [BLOCK-1:0] w_b;
        logic [BLOCK-1:0] w_s;
        logic             w_cin;
        logic             w_c;
        logic             r_cy;
        logic [BLOCK-1:0] r_s_dly [NSTG-gk];

        if (gk == 0) begin : g_first
            assign w_a   = in_A[BLOCK-1:0];
            assign w_b   = w_b_eff[BLOCK-1:0];
            assign w_cin = w_cin0;
        end else begin : g_skew
            logic [BLOCK-1:0] r_a_dly [gk];
            logic [BLOCK-1:0] r_b_dly [gk];

            // Operand slice rides through stages 0..gk-1 until its block's carry is ready.
            always_ff @(posedge in_CLK or negedge in_RST_N) begin
                if (!in_RST_N) begin
                    for (int d = 0; d < gk; d++) begin
                        r_a_dly[d] <= '0;
                        r_b_dly[d] <= '0;
                    end
                end else begin
                    if (w_adv[0]) begin
                        r_a_dly[0] <= in_A[gk*BLOCK +: BLOCK];
                        r_b_dly[0] <= w_b_eff[gk*BLOCK +: BLOCK];
                    end
                    for (int d = 1; d < gk; d++) begin
                        if (w_adv[d]) begin
                            r_a_dly[d] <= r_a_dly[d-1];
                            r_b_dly[d] <= r_b_dly[d-1];
                        end
                    end
                end
            end

            assign w_a   = r_a_dly[gk-1];
            assign w_b   = r_b_dly[gk-1];
            assign w_cin = w_cy[gk-1];
        end

        csel_block #(
            .BLOCK (BLOCK)
        ) u_csel (
            .i_a   (w_a),
            .i_b   (w_b),
            .i_cin (w_cin),
            .o_s   (w_s),
            .o_c   (w_c)
        );

        // Carry for the next block, plus the result slice's delay line out to the final stage.
        always_ff @(posedge in_CLK or negedge in_RST_N) begin
            if (!in_RST_N) begin
                r_cy <= 1'b0;
                for (int d = 0; d < NSTG - gk; d++) begin
                    r_s_dly[d] <= '0;
                end
            end else begin
                if (w_adv[gk]) begin
                    r_cy       <= w_c;
                    r_s_dly[0] <= w_s;
                end
                for (int d = 1; d < NSTG - gk; d++) begin
                    if (w_adv[gk+d]) begin
                        r_s_dly[d] <= r_s_dly[d-1];
                    end
                end
            end
        end

        assign w_cy[gk]                  = r_cy;
        assign out_S[gk*BLOCK +: BLOCK]  = r_s_dly[NSTG-1-gk];

        if (gk == NSTG - 1) begin : g_ovf
            logic r_v;

            // Carry into the MSB equals a^b^s at that bit, so overflow needs no extra adder tap.
            always_ff @(posedge in_CLK or negedge in_RST_N) begin
                if (!in_RST_N) begin
                    r_v <= 1'b0;
                end else if (w_adv[gk]) begin
                    r_v <= w_a[BLOCK-1] ^ w_b[BLOCK-1] ^ w_s[BLOCK-1] ^ w_c;
                end
            end

            assign out_V = r_v;
        end
    end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder (WIDTH=16, BLOCK=4): arithmetic model plus directed and random traffic.
// Latency: expects 4 cycles from handshake to out_VALID.
// Backpressure: drives in_READY stalls and checks hold/ordering.
module tb_pipelined_csel_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_VALID;
    logic         out_READY;
    logic [W-1:0] in_A;
    logic [W-1:0] in_B;
    logic         in_C;
    logic         in_SUB;
    logic         out_VALID;
    logic         in_READY;
    logic [W-1:0] out_S;
    logic         out_C;
    logic         out_V;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] retired[$];
    logic         prev_stall = 1'b0;
    res_t         prev_out;

    pipelined_csel_adder #(
        .WIDTH (16),
        .BLOCK (4)
    ) dut (
        .in_CLK    (clk),
        .in_RST_N  (rst_n),
        .in_VALID  (in_VALID),
        .out_READY (out_READY),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_C      (in_C),
        .in_SUB    (in_SUB),
        .out_VALID (out_VALID),
        .in_READY  (in_READY),
        .out_S     (out_S),
        .out_C     (out_C),
        .out_V     (out_V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Plain-integer reference: signed range test for V, unsigned compare for carry/borrow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub);
        res_t        r;
        int          sa, sb, ts;
        int unsigned ua, ub, tu;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = {16'd0, a};
        ub = {16'd0, b};
        if (sub) begin
            ts  = sa - sb;
            tu  = ua - ub;
            r.c = (ua >= ub);
        end else begin
            ts  = sa + sb + int'(c);
            tu  = ua + ub + {31'd0, c};
            r.c = (tu > 32'd65535);
        end
        r.s = tu[W-1:0];
        r.v = (ts > 32767) || (ts < -32768);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every valid output cycle, check hold while stalled, enqueue on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_VALID || {out_S, out_C, out_V} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: got vld=%0b %0h/%0b/%0b expected held %0h/%0b/%0b",
                             out_VALID, out_S, out_C, out_V, prev_out.s, prev_out.c, prev_out.v);
                end
            end
            if (out_VALID) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out: got S=%0h with no transaction expected", out_S);
                end else begin
                    if ({out_S, out_C, out_V} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL model_cmp: got S=%0h C=%0b V=%0b expected S=%0h C=%0b V=%0b",
                                 out_S, out_C, out_V, exp_q[0].s, exp_q[0].c, exp_q[0].v);
                    end
                    if (in_READY) begin
                        void'(exp_q.pop_front());
                        retired.push_back(out_S);
                    end
                end
            end
            prev_stall = out_VALID && !in_READY;
            prev_out   = {out_S, out_C, out_V};
            if (in_VALID && out_READY) exp_q.push_back(model(in_A, in_B, in_C, in_SUB));
        end
    end

    // Present one transaction; returns the cycle in which the handshake occurred.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, output int acc);
        logic rdy;
        in_A = a; in_B = b; in_C = c; in_SUB = sub; in_VALID = 1'b1;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            rdy = out_READY;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc      = cyc - 1;
                in_VALID = 1'b0;
                return;
            end
        end
        in_VALID = 1'b0;
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_VALID) begin
                at = cyc;
                return;
            end
        end
        chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0, a1, at, tmp, base, nret;
        logic seen;
        res_t m;

        rst_n = 1'b0; in_VALID = 1'b0; in_READY = 1'b1;
        in_A = '0; in_B = '0; in_C = 1'b0; in_SUB = 1'b0;

        // Model sanity against hand-worked values.
        m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("model_add_ovf", {15'd0, m}, {15'd0, 16'h8000, 1'b0, 1'b1});
        m = model(16'h8000, 16'h0001, 1'b1, 1'b1);
        chk("model_sub_ovf", {15'd0, m}, {15'd0, 16'h7FFF, 1'b1, 1'b1});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {out_VALID, out_S, out_C, out_V, out_READY}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", out_READY, 1);
        @(posedge clk); #1;

        // Single add with carry-in: latency and value.
        send(16'h0000, 16'h0000, 1'b1, 1'b0, a0);
        wait_valid(at);
        chk("lat_first", at - a0, 4);
        chk("add_cin_S", out_S, 16'h0001);
        chk("add_cin_CV", {out_C, out_V}, 2'b00);
        @(posedge clk); #1;

        // Back-to-back transactions emerge on consecutive cycles.
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, a0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, a1);
        chk("b2b_accept", a1 - a0, 1);
        wait_valid(at);
        chk("b2b_lat", at - a0, 4);
        chk("b2b_r0", {out_S, out_C, out_V}, {16'h0000, 1'b1, 1'b0});
        @(negedge clk);
        chk("b2b_r1", {out_VALID, out_S, out_C, out_V}, {1'b1, 16'hFFFF, 1'b1, 1'b0});
        @(posedge clk); #1;

        // Signed overflow in both modes; in_C must be ignored when subtracting.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, a0);
        wait_valid(at);
        chk("ovf_add", {out_S, out_C, out_V}, {16'h8000, 1'b0, 1'b1});
        @(posedge clk); #1;
        send(16'h8000, 16'h0001, 1'b1, 1'b1, a0);
        wait_valid(at);
        chk("ovf_sub", {out_S, out_C, out_V}, {16'h7FFF, 1'b1, 1'b1});
        @(posedge clk); #1;

        // Stream of 10 with a stall window: full pipeline refuses input, order preserved.
        base = retired.size();
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'(i), W'(i), 1'b0, 1'b0, tmp);
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    in_READY = !(c >= 3 && c <= 8);
                    @(negedge clk);
                    if (c >= 4 && c <= 8) begin
                        chk("full_rdy", out_READY, 0);
                        chk("full_vld", out_VALID, 1);
                    end
                    @(posedge clk); #1;
                end
                in_READY = 1'b1;
            end
        join
        for (int n = 0; n < 30 && retired.size() < base + 10; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("stream_count", retired.size() - base, 10);
        for (int i = 0; i < 10 && base + i < retired.size(); i++)
            chk("stream_val", retired[base+i], 2 * i);
        @(posedge clk); #1;

        // Reset with three results in flight: all discarded.
        in_READY = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, a0);
        send(16'h0F0F, 16'h0101, 1'b1, 1'b0, a0);
        send(16'h4000, 16'h0001, 1'b0, 1'b1, a0);
        wait_valid(at);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {out_VALID, out_S, out_C, out_V, out_READY}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_READY = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst2", out_READY, 1);
        nret = retired.size();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_VALID) seen = 1'b1;
        end
        chk("rst_no_ghost", seen, 0);
        chk("rst_no_retire", retired.size() - nret, 0);
        @(posedge clk); #1;

        // Random traffic with random and bursty backpressure.
        for (int n = 0; n < 400; n++) begin
            in_VALID = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       in_A = 16'hFFFF;
                1:       in_A = 16'h8000;
                default: in_A = W'($urandom);
            endcase
            in_B     = ($urandom_range(0, 5) == 0) ? 16'h7FFF : W'($urandom);
            in_C     = 1'($urandom_range(0, 1));
            in_SUB   = 1'($urandom_range(0, 1));
            in_READY = ((n % 50) < 8) ? 1'b0 : ($urandom_range(0, 4) != 0);
            @(posedge clk); #1;
        end
        in_VALID = 1'b0;
        in_READY = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
